// File: rtl/dec_rr_arbiter.sv
// Four-requester round-robin arbiter with one-hot grant decoded from a registered winner index.
// A grant ends on done, on the owner dropping its request, or when the optional hold limit expires.
module dec_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [1:0] to_id
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);
  localparam bit HoldEn = (MAX_HOLD != 0);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
  logic [1:0] to_id_q, to_id_d;

  logic       win_found;
  logic [1:0] win_id;
  logic       release_now;
  logic       limit_hit;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_id    = ptr_q + 2'(i);
      end
    end
  end

  assign release_now = done || !req[gnt_id_q];
  assign limit_hit   = HoldEn && (hold_cnt_q == MaxHold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      to_id_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
      to_id_q     <= to_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StBusy;
      StBusy:  if (release_now || limit_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    to_id_d     = to_id_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
          ptr_d       = win_id + 2'd1;
        end
      end
      StBusy: begin
        if (release_now) begin
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else if (limit_hit) begin
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          timeout_d   = 1'b1;
          to_id_d     = gnt_id_q;
        end else if (hold_cnt_q != 8'hff) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // Grant is the registered 2x4 decode of the next owner index.
  always_comb begin
    gnt_d = 4'b0000;
    if (gnt_valid_d) begin
      unique case (gnt_id_d)
        2'd0: gnt_d = 4'b0001;
        2'd1: gnt_d = 4'b0010;
        2'd2: gnt_d = 4'b0100;
        2'd3: gnt_d = 4'b1000;
        default: gnt_d = 4'b0000;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign to_id     = to_id_q;

endmodule

// File: doc/dec_rr_arbiter.md
Name: dec_rr_arbiter

Overview:
- Four-requester round-robin arbiter for a shared single-port resource, such as a decoder-driven gate/function unit.
- Grants are one-hot, produced by decoding a registered 2-bit winner index exactly as a 2x4 decoder would, so at most one requester owns the resource at a time.
- Each grant is held until the owner signals done, drops its request, or exceeds a programmable hold limit.
- Sits between requesting blocks and the shared datapath and drives its select/enable.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held (1..255); 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; held high until served
- done  input  1  owner finished; sampled only while gnt_valid=1
- gnt  output  4  one-hot grant; equals 2x4 decode of gnt_id when gnt_valid=1, else 4'b0000
- gnt_id  output  2  index of current owner
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit
- to_id  output  2  index of requester revoked by the last timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, ptr=2'd0, gnt=4'b0000, gnt_id=2'd0, gnt_valid=0, hold_cnt=8'd0, timeout=0, to_id=2'd0.
- Reset asserted mid-grant clears the grant immediately; no timeout pulse is generated.
- All outputs are registered; gnt is never glitching combinational logic.
- State machine has 2 states: IDLE and BUSY.
- IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4; 3 wraps to 0).
  - Next edge: gnt_id=winner, gnt=decode(winner), gnt_valid=1, hold_cnt=1, ptr=winner+1 (mod 4), state=BUSY.
  - If req == 0, stay in IDLE; ptr is unchanged.
- Latency: req rising in cycle N (state IDLE) gives gnt asserted from cycle N+1.
- BUSY, release conditions, evaluated each edge with this priority:
  - (a) done=1 or req[gnt_id]=0: release. gnt=0, gnt_valid=0, state=IDLE, no timeout.
  - (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD: revoke. gnt=0, gnt_valid=0, timeout=1 for exactly one cycle, to_id=gnt_id, state=IDLE.
  - (c) otherwise hold_cnt increments; it saturates at 255.
- Simultaneous done and limit in the same cycle: done wins, so no timeout pulse.
- Every grant is followed by at least one IDLE cycle (gnt=0) before the next grant, giving a guaranteed resource turnaround cycle.
- Requests from non-owners during BUSY are ignored and have no effect on ptr.
- Fairness: ptr advances past the last winner on every grant, including grants that end in timeout. With all 4 requesting continuously, grant order is 0,1,2,3,0,...
- Requests changing while in IDLE: arbitration uses req as sampled on the granting edge only.
- done while IDLE is ignored.
- to_id holds its value until the next timeout or reset.
- gnt_id holds the last owner after release; consumers must qualify it with gnt_valid.

Test Plan:
- Reset/idle: assert rst_n=0 mid-BUSY (req=4'b0100 granted) -> gnt=0000, gnt_valid=0, ptr=0 immediately, no timeout pulse. After release with req=0 -> outputs stay 0.
- Single requester: req=4'b0010 at cycle 5 -> gnt=0010, gnt_id=1 from cycle 6. done=1 at cycle 9 -> gnt=0000 at cycle 10. Re-grant at cycle 11 if req still high.
- Round-robin wrap: req=4'b1111 held, done pulsed each BUSY cycle -> grant sequence 0001,0100? No: 0001,0010,0100,1000,0001, each separated by one zero cycle.
- Pointer skip: after grant to 1 (ptr=2), req=4'b0011 -> next grant goes to 0 (search order 2,3,0) -> gnt=0001.
- Timeout: MAX_HOLD=4, req=4'b1000, done never asserted -> gnt=1000 for exactly 4 cycles, then gnt=0000 with timeout=1 for one cycle, to_id=3. Next grant comes after the IDLE cycle.
- Boundary races:
  - done=1 on the same cycle hold_cnt==MAX_HOLD -> no timeout pulse.
  - Owner drops req mid-grant -> release next edge, timeout=0.
  - MAX_HOLD=0 -> grant held for 300 cycles without timeout.
